ahb_bram_ctrl: RTL
==================

// Module: ahb_bram_ctrl
// PURPOSE
//  AHB-Lite slave that drives the Block_RAM ports: byte-write port A (addra/wea/dina)
//  and registered read port B (addrb/doutb, 1-cycle latency). Sits between the
//  Cortex-M0 bus matrix and the code/data RAM. Zero-wait reads and writes, one wait
//  state on a read-after-write hazard, and a two-cycle ERROR response on unaligned access.
// PARAMETERS
//  ADDR_WIDTH  12  RAM word-address width; RAM size = 4*2**ADDR_WIDTH bytes
// PORTS
//  clka       in   1           clock (bus and RAM share it)
//  rst        in   1           synchronous, active-high reset
//  HSEL       in   1           slave select
//  HADDR      in   32          byte address; only [ADDR_WIDTH+1:0] used (upper bits ignored, wraps)
//  HTRANS     in   2           NONSEQ=2'b10 / SEQ=2'b11 valid; IDLE/BUSY ignored
//  HSIZE      in   3           0=byte, 1=half, 2=word; >2 treated as unaligned -> ERROR
//  HWRITE     in   1           1=write
//  HWDATA     in   32          write data (data phase)
//  HREADY     in   1           bus-wide ready; address phase sampled only when 1
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0=OKAY, 1=ERROR
//  HRDATA     out  32          read data (= doutb)
//  addra      out  ADDR_WIDTH  RAM write word address
//  wea        out  4           RAM byte write enables
//  dina       out  32          RAM write data (= HWDATA)
//  addrb      out  ADDR_WIDTH  RAM read word address
//  doutb      in   32          RAM read data, valid 1 cycle after addrb sampled
// BEHAVIOUR
//  - Reset: HREADYOUT=1, HRESP=0, wea=0, state=IDLE, pending write/read flags cleared.
//    Reset mid-transfer drops any pending write (no wea) and any stall/error.
//  - Transfer accepted when HSEL & HTRANS[1] & HREADY. Latch addr word, byte lane, size, write.
//  - Byte lanes: byte -> 1<<HADDR[1:0]; half -> 4'b0011<<HADDR[1:0]; word -> 4'b1111.
//  - Unaligned: half with HADDR[0]=1, word with HADDR[1:0]!=0, or HSIZE>2.
//  - States: IDLE, WR (write data phase), RD (read data phase), STALL, ERR1, ERR2.
//    IDLE/WR/RD accept a new address phase; next state per accepted transfer
//    (write->WR, read->RD or STALL, unaligned->ERR1, none->IDLE).
//  - WR: wea = latched lanes, addra = latched word, dina = HWDATA; RAM updates at cycle end.
//    HREADYOUT=1. wea=0 in every other state.
//  - RD: HREADYOUT=1, HRDATA=doutb. addrb = HADDR word in address phase (combinational),
//    so zero wait states.
//  - Hazard: read accepted while in WR to the same word -> next state STALL:
//    HREADYOUT=0, addrb held at latched read word; then RD.
//    Read to a different word: no stall.
//  - ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1; no RAM access.
//    Address phase presented during ERR2 is accepted per AHB (HREADY=1).
//  - In STALL/ERR1 (HREADYOUT=0) no new address phase is sampled; addrb = latched word.
//  - HRDATA is don't-care outside RD; drive doutb anyway.
//  - Back-to-back SEQ/NONSEQ writes and reads are full-throughput.
//    Write->write to the same word: both apply in order.
// TESTING
//  1. Reset: assert rst 2 cycles mid-write -> wea=0, HREADYOUT=1, HRESP=0, RAM unchanged.
//  2. Word write 0xDEADBEEF @0x10, then read @0x10 next cycle -> one stall cycle
//     (HREADYOUT=0), then HRDATA=0xDEADBEEF.
//  3. Byte writes 0x11,0x22,0x33,0x44 @0x20..0x23, then word read @0x20 after an
//     IDLE cycle -> 0x44332211, zero wait states.
//  4. Half write 0xABCD @0x32 -> wea=4'b1100; word read @0x30 -> upper half 0xABCD,
//     lower half unchanged.
//  5. Word write @0x41 -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1), wea stays 0,
//     RAM @0x40 unchanged.
//  6. Write @0x0 and read @(4<<ADDR_WIDTH) -> address wraps to word 0, data matches;
//     HTRANS=IDLE/BUSY or HSEL=0 -> no wea, HREADYOUT=1.

Source files
------------

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave driving a byte-write port A / registered-read port B block RAM
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [3:0]            wea,
    output logic [31:0]           dina,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [31:0]           doutb
);
    typedef enum logic [2:0] {IDLE, WR, RD, STALL, ERR1, ERR2} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [3:0]            lanes_q;
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [3:0]            lanes;
    logic                  accept;
    logic                  unaligned;
    logic                  unused;
    assign unused     = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
    assign haddr_word = HADDR[ADDR_WIDTH+1:2];
    assign accept     = HSEL & HTRANS[1] & HREADY & HREADYOUT;
    assign unaligned  = (HSIZE > 3'd2) || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign lanes      = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? 4'b0011 << HADDR[1:0] : 4'b1111;
    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            word_q    <= '0;
            lanes_q   <= '0;
        end else if (accept) begin
            word_q  <= haddr_word;
            lanes_q <= lanes;
            HRESP   <= unaligned;
            // a read of the word being written this cycle would see stale RAM data
            if (unaligned) begin
                state     <= ERR1;
                HREADYOUT <= 1'b0;
            end else if (HWRITE) begin
                state     <= WR;
                HREADYOUT <= 1'b1;
            end else if (state == WR && haddr_word == word_q) begin
                state     <= STALL;
                HREADYOUT <= 1'b0;
            end else begin
                state     <= RD;
                HREADYOUT <= 1'b1;
            end
        end else begin
            state     <= state == STALL ? RD : state == ERR1 ? ERR2 : IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= state == ERR1;
        end
    end
    assign addra  = word_q;
    assign wea    = state == WR ? lanes_q : 4'b0000;
    assign dina   = HWDATA;
    assign addrb  = (state == STALL || state == ERR1) ? word_q : haddr_word;
    assign HRDATA = doutb;
endmodule
